// File: rtl/time_set_ctrl.sv
// Front-panel controller: debounces MODE/INC, walks RUN/SET_HOUR/SET_MIN/SET_SEC,
// and drives the field increment pulses with hold-to-repeat and an inactivity timeout.
`timescale 1ns/1ps

module time_set_ctrl #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_DLY   = 50000000,
  parameter int REPEAT_PER   = 10000000,
  parameter int TIMEOUT_S    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick_1hz,
  output logic       enb_cnt,
  output logic [1:0] sel,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       blink
);

  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HOLD_W = $clog2(REPEAT_DLY + 1);
  localparam int TO_W   = $clog2(TIMEOUT_S + 1);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DLY);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DLY - REPEAT_PER + 1);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_S);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  // Button index 0 is MODE, index 1 is INC.
  logic [1:0]      rawBtn;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      db_q;
  logic [1:0]      dbPrev_q;
  logic [DB_W-1:0] dbCnt_q [2];

  state_e            state_q;
  state_e            state_d;
  logic              enbCnt_q;
  logic              incHour_q;
  logic              incMin_q;
  logic              incSec_q;
  logic              blink_q;
  logic [HOLD_W-1:0] holdCnt_q;
  logic [TO_W-1:0]   tickCnt_q;

  logic modePress;
  logic incPress;
  logic inSet;
  logic timeoutHit;
  logic stateChange;
  logic incEvent;
  logic repeatFire;
  logic fieldPulse;

  assign rawBtn = {btn_inc, btn_mode};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      dbPrev_q <= '0;
      for (int i = 0; i < 2; i++) begin
        dbCnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= rawBtn;
      sync2_q  <= sync1_q;
      dbPrev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          dbCnt_q[i] <= '0;
        end else if (dbCnt_q[i] == DB_LAST) begin
          db_q[i]    <= ~db_q[i];
          dbCnt_q[i] <= '0;
        end else begin
          dbCnt_q[i] <= dbCnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign modePress = db_q[0] & ~dbPrev_q[0];
  assign incPress  = db_q[1] & ~dbPrev_q[1];

  assign inSet      = (state_q != RUN);
  assign timeoutHit = inSet && (tickCnt_q == TO_LAST);

  // Timeout takes priority over a coincident MODE press.
  always_comb begin
    state_d = state_q;
    if (timeoutHit) begin
      state_d = RUN;
    end else if (modePress) begin
      state_d = state_e'(state_q + 2'd1);
    end
  end

  assign stateChange = (state_d != state_q);
  assign incEvent    = inSet && !stateChange && incPress;
  assign repeatFire  = inSet && !stateChange && db_q[1] && (holdCnt_q == HOLD_FIRE);
  assign fieldPulse  = incEvent || repeatFire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      enbCnt_q  <= 1'b1;
      incHour_q <= 1'b0;
      incMin_q  <= 1'b0;
      incSec_q  <= 1'b0;
      blink_q   <= 1'b0;
      holdCnt_q <= '0;
      tickCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      enbCnt_q  <= (state_d == RUN);
      incHour_q <= fieldPulse && (state_q == SET_HOUR);
      incMin_q  <= fieldPulse && (state_q == SET_MIN);
      incSec_q  <= fieldPulse && (state_q == SET_SEC);

      // Zero means no hold in progress; after each repeat the counter is
      // rewound so the next one lands REPEAT_PER cycles later.
      if (stateChange || !inSet || !db_q[1]) begin
        holdCnt_q <= '0;
      end else if (incEvent) begin
        holdCnt_q <= HOLD_W'(1);
      end else if (repeatFire) begin
        holdCnt_q <= HOLD_RELOAD;
      end else if (holdCnt_q != '0) begin
        holdCnt_q <= holdCnt_q + HOLD_W'(1);
      end

      if (stateChange || !inSet || modePress || incPress || repeatFire) begin
        tickCnt_q <= '0;
      end else if (tick_1hz) begin
        tickCnt_q <= tickCnt_q + TO_W'(1);
      end

      if (stateChange || !inSet) begin
        blink_q <= 1'b0;
      end else if (tick_1hz) begin
        blink_q <= ~blink_q;
      end
    end
  end

  assign sel      = state_q;
  assign enb_cnt  = enbCnt_q;
  assign inc_hour = incHour_q;
  assign inc_min  = incMin_q;
  assign inc_sec  = incSec_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/repeat/timeout parameters.
`timescale 1ns/1ps

module tb_time_set_ctrl;

  localparam int DEBOUNCE_CYC = 4;
  localparam int REPEAT_DLY   = 20;
  localparam int REPEAT_PER   = 5;
  localparam int TIMEOUT_S    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       enb_cnt;
  logic [1:0] sel;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_sec;
  logic       blink;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hourCnt = 0;
  int minCnt = 0;
  int secCnt = 0;
  int multiHot = 0;
  int hourTimes[$];
  int repeatOffs[6] = '{0, 20, 25, 30, 35, 40};
  int base;
  int pressCyc;

  time_set_ctrl #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_PER  (REPEAT_PER),
    .TIMEOUT_S   (TIMEOUT_S)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .tick_1hz(tick_1hz),
    .enb_cnt (enb_cnt),
    .sel     (sel),
    .inc_hour(inc_hour),
    .inc_min (inc_min),
    .inc_sec (inc_sec),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log sampled mid-cycle; cyc holds the number of edges seen so far.
  always @(negedge clk) begin
    if (inc_hour === 1'b1) begin
      hourCnt++;
      hourTimes.push_back(cyc);
    end
    if (inc_min === 1'b1) minCnt++;
    if (inc_sec === 1'b1) secCnt++;
    if (int'(inc_hour) + int'(inc_min) + int'(inc_sec) > 1) multiHot++;
  end

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic m, input logic i, input int n);
    btn_mode = m;
    btn_inc  = i;
    waitNeg(n);
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pressMode();
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 10);
  endtask

  // Raw rise lands before edge N; sel must still be old after N+5 and new after N+6.
  task automatic timedModePress(input int oldSel, input int newSel, input string tag);
    btn_mode = 1'b1;
    waitNeg(6);
    checkOutput({tag, "_before"}, int'(sel), oldSel);
    waitNeg(1);
    checkOutput({tag, "_after"}, int'(sel), newSel);
    checkOutput({tag, "_enb"}, int'(enb_cnt), (newSel == 0) ? 1 : 0);
    waitNeg(3);
    applyStimulus(1'b0, 1'b0, 10);
  endtask

  task automatic applyTick();
    tick_1hz = 1'b1;
    waitNeg(1);
    tick_1hz = 1'b0;
  endtask

  function automatic int totalPulses();
    return hourCnt + minCnt + secCnt;
  endfunction

  initial begin
    waitNeg(1);
    for (int k = 0; k < 3; k++) begin
      btn_mode = k[0];
      btn_inc  = ~k[0];
      waitNeg(1);
    end
    checkOutput("rst_enb", int'(enb_cnt), 1);
    checkOutput("rst_sel", int'(sel), 0);
    checkOutput("rst_blink", int'(blink), 0);
    checkOutput("rst_pulses", totalPulses(), 0);

    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    rst_n    = 1'b1;
    waitNeg(10);
    checkOutput("post_rst_enb", int'(enb_cnt), 1);
    checkOutput("post_rst_sel", int'(sel), 0);
    checkOutput("post_rst_blink", int'(blink), 0);
    checkOutput("post_rst_pulses", totalPulses(), 0);

    timedModePress(0, 1, "mode1");
    timedModePress(1, 2, "mode2");
    timedModePress(2, 3, "mode3");
    timedModePress(3, 0, "mode4");

    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("glitch_sel", int'(sel), 0);

    pressMode();
    pressMode();
    checkOutput("setmin_sel", int'(sel), 2);
    base = hourCnt;
    pressCyc = secCnt;
    checks++;
    begin
      int minBase;
      minBase = minCnt;
      applyStimulus(1'b0, 1'b1, 8);
      applyStimulus(1'b0, 1'b0, 12);
      checks--;
      checkOutput("inc_min_once", minCnt - minBase, 1);
    end
    checkOutput("inc_hour_idle", hourCnt - base, 0);
    checkOutput("inc_sec_idle", secCnt - pressCyc, 0);

    pressMode();
    pressMode();
    pressMode();
    checkOutput("sethour_sel", int'(sel), 1);
    hourTimes.delete();
    pressCyc = cyc + 7;
    applyStimulus(1'b0, 1'b1, 43);
    applyStimulus(1'b0, 1'b0, 30);
    checkOutput("repeat_count", hourTimes.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < hourTimes.size()) begin
        checkOutput($sformatf("repeat_at_%0d", k), hourTimes[k], pressCyc + repeatOffs[k]);
      end
    end

    pressMode();
    pressMode();
    pressMode();
    checkOutput("run_sel", int'(sel), 0);
    base = totalPulses();
    applyStimulus(1'b0, 1'b1, 40);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("run_inc_ignored", totalPulses() - base, 0);

    pressMode();
    checkOutput("simul_pre_sel", int'(sel), 1);
    base = totalPulses();
    applyStimulus(1'b1, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("simul_sel", int'(sel), 2);
    checkOutput("simul_no_inc", totalPulses() - base, 0);

    pressMode();
    checkOutput("setsec_sel", int'(sel), 3);
    checkOutput("setsec_blink0", int'(blink), 0);
    applyTick();
    waitNeg(9);
    checkOutput("tick1_blink", int'(blink), 1);
    applyTick();
    waitNeg(9);
    checkOutput("tick2_blink", int'(blink), 0);
    applyTick();
    checkOutput("tick3_sel", int'(sel), 3);
    checkOutput("tick3_blink", int'(blink), 1);
    waitNeg(1);
    checkOutput("timeout_sel", int'(sel), 0);
    checkOutput("timeout_enb", int'(enb_cnt), 1);
    checkOutput("timeout_blink", int'(blink), 0);
    waitNeg(8);

    pressMode();
    pressMode();
    pressMode();
    checkOutput("restart_sel", int'(sel), 3);
    applyTick();
    waitNeg(9);
    applyTick();
    waitNeg(9);
    base = secCnt;
    applyStimulus(1'b0, 1'b1, 8);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("restart_inc_sec", secCnt - base, 1);
    applyTick();
    waitNeg(9);
    applyTick();
    waitNeg(9);
    checkOutput("restart_two_ticks", int'(sel), 3);
    applyTick();
    checkOutput("restart_third_tick", int'(sel), 3);
    waitNeg(1);
    checkOutput("restart_timeout", int'(sel), 0);
    waitNeg(8);

    pressMode();
    checkOutput("abort_pre_sel", int'(sel), 1);
    base = hourCnt;
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("abort_press", hourCnt - base, 1);
    rst_n = 1'b0;
    waitNeg(1);
    checkOutput("abort_sel", int'(sel), 0);
    checkOutput("abort_enb", int'(enb_cnt), 1);
    checkOutput("abort_inc_hour", int'(inc_hour), 0);
    waitNeg(2);
    btn_inc = 1'b0;
    rst_n   = 1'b1;
    waitNeg(12);
    checkOutput("abort_post_sel", int'(sel), 0);
    checkOutput("abort_no_more", hourCnt - base, 1);

    checkOutput("one_hot_inc", multiHot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-panel controller for the digital clock datapath.
- Debounces the MODE and INC push-buttons and runs the RUN/SET_HOUR/SET_MIN/SET_SEC sequence.
- Gates the time counters with enb_cnt and issues one-cycle increment pulses to the selected hour/minute/second field, with hold-to-repeat.
- Drops back to RUN automatically after a period of panel inactivity.

Parameters:
- DEBOUNCE_CYC, 1000000: consecutive stable cycles required before a debounced button changes level.
- REPEAT_DLY, 50000000: cycles INC must be held (debounced) before auto-repeat starts.
- REPEAT_PER, 10000000: cycles between auto-repeat pulses.
- TIMEOUT_S, 10: tick_1hz pulses with no button press in a SET state before returning to RUN.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- btn_mode  input  1  raw MODE button, asynchronous, active-high
- btn_inc  input  1  raw INC button, asynchronous, active-high
- tick_1hz  input  1  one-cycle pulse once per second, synchronous to clk
- enb_cnt  output  1  1 = time counters run; 0 = counting frozen
- sel  output  2  field selected: 0 RUN, 1 hour, 2 minute, 3 second
- inc_hour  output  1  one-cycle increment pulse to hour field
- inc_min  output  1  one-cycle increment pulse to minute field
- inc_sec  output  1  one-cycle increment pulse to second field
- blink  output  1  display blink for selected field; toggles per tick_1hz in SET states

Behaviour:
- Clock and reset: single clock domain. Reset is sampled on the clk rising edge only.
- Reset state (rst_n=0 at an edge):
  - state=RUN, enb_cnt=1, sel=0, all inc_* = 0, blink=0.
  - Synchronisers, debounced levels, debounce, repeat and timeout counters all 0.
  - Reset asserted mid-hold or mid-SET aborts immediately; no pulse is emitted on the reset edge.
- Synchronisation: each raw button passes through a 2-flop synchroniser.
- Debounce: per button, a counter increments while the synced value differs from the debounced level, and clears when they are equal. When the counter reaches DEBOUNCE_CYC-1 and still differs, the debounced level flips and the counter clears. Glitches shorter than DEBOUNCE_CYC cycles are rejected.
- Press: rising edge of a debounced level, one cycle wide. Release produces no event.
- Latency: a raw press held steady produces its registered effect exactly DEBOUNCE_CYC+3 rising edges after the first edge that samples it high.
- FSM on mode_press: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN (wraps).
  - sel equals the state code.
  - enb_cnt=1 only in RUN.
  - All outputs are registered.
- INC in a SET state:
  - inc_press gives one pulse on the inc_* line of the current field.
  - In RUN, inc_press and repeat are ignored.
- Auto-repeat:
  - While debounced INC stays high in a SET state, a hold counter counts from the press.
  - The first repeat pulse comes REPEAT_DLY cycles after the press pulse; subsequent pulses come every REPEAT_PER cycles.
  - Release, a state change, or reset stops the repeat and clears the counter.
- Simultaneous events:
  - mode_press and inc_press in the same cycle: mode wins, state advances, no inc pulse.
  - A repeat pulse due in the same cycle as mode_press is suppressed.
  - Only one inc_* line is high in any cycle.
- Timeout:
  - In SET states, a tick counter increments on tick_1hz and clears on any press or repeat pulse.
  - Reaching TIMEOUT_S forces RUN on the next edge. The counter clears on entering RUN.
  - tick_1hz coincident with a press: the press clears the counter and the tick is not counted.
- blink: 0 in RUN; cleared on each state transition; toggles on every tick_1hz while in a SET state.
- Field wrap-around (23->0, 59->0) belongs to the datapath counters, not this block.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DLY=20, REPEAT_PER=5, TIMEOUT_S=3 unless stated):
- Reset behaviour: hold rst_n=0 for 3 cycles with buttons toggling -> enb_cnt=1, sel=0, blink=0, no inc_* pulses. Release reset -> outputs unchanged.
- Mode cycling: four clean MODE presses, each 10 cycles high with 10-cycle gaps -> sel goes 1,2,3,0. enb_cnt=0 while sel!=0. Each sel change occurs exactly 7 edges after the raw rise.
- Glitch rejection: btn_mode high for 3 cycles, then low -> no state change. In SET_MIN, an INC press held 8 cycles -> exactly one inc_min pulse; inc_hour and inc_sec stay 0.
- Auto-repeat: in SET_HOUR, hold INC for 40 cycles after the press pulse -> inc_hour pulses at press, +20, +25, +30, +35, +40. Release -> pulses stop. INC held in RUN -> no pulses.
- Simultaneous press: raw MODE and INC rise on the same edge in SET_HOUR -> sel=2 and no inc pulse of any kind.
- Timeout and blink: enter SET_SEC, then apply 3 tick_1hz pulses 10 cycles apart with no press -> blink toggles 0->1->0, then sel=0 and enb_cnt=1 after the third tick. An INC press after the 2nd tick restarts the count, so 3 further ticks are needed.
